// File: rtl/pc.sv
// Program counter register: holds the fetch address and loads the next PC on a write strobe.
// Optional misalignment flag for the trap logic is enabled with `define PC_ALIGN_CHECK_EN.
module pc #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             Write_enable,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] pc_plus4
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             misalign
`endif
);

  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_q;

  // Reset beats the load strobe; misaligned addresses are stored verbatim.
  always_comb begin
    pc_d = pc_q;
    if (rst) begin
      pc_d = RESET_VECTOR;
    end else if (Write_enable) begin
      pc_d = data_in;
    end
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  assign data_out = pc_q;
  assign pc_plus4 = pc_q + WIDTH'(4);

`ifdef PC_ALIGN_CHECK_EN
  assign misalign = |pc_q[1:0];
`endif

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: directed sequence followed by random stimulus against a
// behavioural next-PC model.
module tb_pc;

  localparam int unsigned WIDTH = 32;
  localparam logic [WIDTH-1:0] RV = 32'h0000_0000;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic             Write_enable;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] pc_plus4;
`ifdef PC_ALIGN_CHECK_EN
  logic             misalign;
`endif

  pc #(.WIDTH(WIDTH), .RESET_VECTOR(RV)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .Write_enable (Write_enable),
    .data_out     (data_out),
    .pc_plus4     (pc_plus4)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misalign     (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [WIDTH-1:0] exp_pc;
  bit               exp_valid = 1'b0;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [WIDTH-1:0] exp_plus4;
    exp_plus4 = exp_pc + 32'd4;
    check({tag, ".data_out"}, data_out, exp_pc);
    check({tag, ".pc_plus4"}, pc_plus4, exp_plus4);
`ifdef PC_ALIGN_CHECK_EN
    check({tag, ".misalign"}, {31'd0, misalign}, {31'd0, (exp_pc[1:0] != 2'b00)});
`endif
  endtask

  // Drive one set of inputs, confirm they do not leak combinationally, clock once,
  // advance the model and compare.
  task automatic cycle(input string tag, input logic r, input logic we, input logic [WIDTH-1:0] din);
    rst          = r;
    Write_enable = we;
    data_in      = din;
    #1;
    if (exp_valid) check({tag, ".nocomb"}, data_out, exp_pc);
    @(posedge clk);
    if (r) begin
      exp_pc    = RV;
      exp_valid = 1'b1;
    end else if (we) begin
      exp_pc = din;
    end
    #1;
    if (exp_valid) check_outputs(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] din;
    logic             r;
    logic             we;
    rst          = 1'b1;
    Write_enable = 1'b1;
    data_in      = 32'hDEAD_BEEF;
    exp_pc       = '0;

    cycle("reset", 1'b1, 1'b1, 32'hDEAD_BEEF);
    cycle("load", 1'b0, 1'b1, 32'h1234_5678);
    for (int i = 0; i < 3; i++) cycle("hold", 1'b0, 1'b0, 32'hABCD_EF01);
    cycle("reload", 1'b0, 1'b1, 32'h8765_4321);
    cycle("wrap", 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle("odd", 1'b0, 1'b1, 32'hFFFF_FFFF);
    cycle("b2b0", 1'b0, 1'b1, 32'h0000_0100);
    cycle("b2b1", 1'b0, 1'b1, 32'h0000_0104);
    cycle("b2b2", 1'b0, 1'b1, 32'h0000_0108);
    cycle("rst_mid", 1'b1, 1'b1, 32'h5555_5556);
    cycle("rst_hold", 1'b1, 1'b0, 32'h7777_7777);

    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 15) == 0);
      we = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0:       din = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        default: din = 32'($urandom);
      endcase
      cycle("rand", r, we, din);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
